bsg_chip_noc_mc_credit_gate: RTL and testbench

- Sits on the manycore side, directly upstream of the forward SDR link and downstream of the reverse SDR link.
- Meters forward (request) packets against a count of outstanding responses, so the remote side never holds more than max_out_credits_p unanswered requests.
- Forward path: buffered in a 2-entry FIFO. Reverse path: combinational pass-through; each accepted return packet releases one credit.
- Provides a drain state machine used before link reset or tag reprogramming.

---
 rtl/bsg_chip_noc_mc_credit_gate.sv | 171 +++++++++++++++++
 tb/tb_bsg_chip_noc_mc_credit_gate.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_chip_noc_mc_credit_gate.sv
// bsg_chip_noc_mc_credit_gate
// Meters forward request packets against outstanding responses. Forward
// traffic is buffered in a 2-entry FIFO. Each accepted return packet frees
// one credit, and return packets pass straight through.
// A drain FSM holds off new requests until the link is quiescent.
// Optional statistics outputs: define BSG_MC_CREDIT_GATE_STATS_EN.
module bsg_chip_noc_mc_credit_gate #(
  parameter  int unsigned fwd_width_p       = 100,
  parameter  int unsigned rev_width_p       = 40,
  parameter  int unsigned max_out_credits_p = 32,
  localparam int unsigned credit_width_lp   =
    (max_out_credits_p < 1) ? 1 : $clog2(max_out_credits_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic                       fwd_v_i,
  input  logic [fwd_width_p-1:0]     fwd_data_i,
  output logic                       fwd_ready_and_o,

  output logic                       fwd_v_o,
  output logic [fwd_width_p-1:0]     fwd_data_o,
  input  logic                       fwd_ready_and_i,

  input  logic                       rev_v_i,
  input  logic [rev_width_p-1:0]     rev_data_i,
  output logic                       rev_ready_and_o,

  output logic                       rev_v_o,
  output logic [rev_width_p-1:0]     rev_data_o,
  input  logic                       rev_ready_and_i,

  input  logic                       drain_i,
  output logic                       drained_o,
  output logic [credit_width_lp-1:0] credits_used_o,
  output logic                       error_o
`ifdef BSG_MC_CREDIT_GATE_STATS_EN
  ,
  output logic [31:0]                stall_cycles_o,
  output logic [credit_width_lp-1:0] max_used_o
`endif
);

  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  typedef enum logic [1:0] {
    eRun     = 2'd0,
    eDrain   = 2'd1,
    eDrained = 2'd2
  } state_e;

  state_e                     state_r, state_n;
  logic [credit_width_lp-1:0] credits_r, credits_n;
  logic                       error_r, error_n;

  logic [fwd_width_p-1:0]     mem_r [2];
  logic                       wr_ptr_r, rd_ptr_r;
  logic [1:0]                 count_r;
  logic                       fifo_full, fifo_empty;
  logic                       enq, deq, rev_xfer;

  assign fifo_full  = (count_r == 2'd2);
  assign fifo_empty = (count_r == 2'd0);

  // Ready depends only on registered state, never on the same-cycle dequeue.
  assign fwd_ready_and_o = (state_r == eRun) & ~fifo_full & (credits_r < max_credits_lp);

  assign enq      = fwd_v_i & fwd_ready_and_o;
  assign deq      = fwd_v_o & fwd_ready_and_i;
  assign rev_xfer = rev_v_i & rev_ready_and_i;

  assign fwd_v_o    = ~fifo_empty;
  assign fwd_data_o = mem_r[rd_ptr_r];

  assign rev_v_o         = rev_v_i;
  assign rev_data_o      = rev_data_i;
  assign rev_ready_and_o = rev_ready_and_i;

  assign drained_o      = (state_r == eDrained);
  assign credits_used_o = credits_r;
  assign error_o        = error_r;

  // FIFO storage; contents are don't-care while the entry is empty.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= fwd_data_i;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (enq) wr_ptr_r <= ~wr_ptr_r;
      if (deq) rd_ptr_r <= ~rd_ptr_r;
      case ({enq, deq})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Credit counter next value; a return with nothing outstanding flags an error.
  always_comb begin
    credits_n = credits_r;
    error_n   = error_r;
    case ({enq, rev_xfer})
      2'b10: credits_n = credits_r + credit_width_lp'(1);
      2'b01: begin
        if (credits_r == '0) error_n   = 1'b1;
        else                 credits_n = credits_r - credit_width_lp'(1);
      end
      default: credits_n = credits_r;
    endcase
  end

  // Credit counter and sticky error register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credits_r <= '0;
      error_r   <= 1'b0;
    end else begin
      credits_r <= credits_n;
      error_r   <= error_n;
    end
  end

  // Drain FSM next state; leaving drain takes priority over completing it.
  always_comb begin
    state_n = state_r;
    case (state_r)
      eRun:     if (drain_i) state_n = eDrain;
      eDrain: begin
        if (!drain_i)                              state_n = eRun;
        else if (fifo_empty && credits_r == '0)    state_n = eDrained;
      end
      eDrained: if (!drain_i) state_n = eRun;
      default:  state_n = eRun;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= eRun;
    else         state_r <= state_n;
  end

`ifdef BSG_MC_CREDIT_GATE_STATS_EN
  logic [31:0]                stall_r;
  logic [credit_width_lp-1:0] max_used_r;

  assign stall_cycles_o = stall_r;
  assign max_used_o     = max_used_r;

  // Stall counter (saturating) and credit high-water mark.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_r    <= '0;
      max_used_r <= '0;
    end else begin
      if (fwd_v_i && (credits_r == max_credits_lp) && (state_r == eRun) && (stall_r != '1))
        stall_r <= stall_r + 32'd1;
      if (credits_n > max_used_r)
        max_used_r <= credits_n;
    end
  end
`endif

endmodule

// File: tb/tb_bsg_chip_noc_mc_credit_gate.sv
// Directed self-checking bench for bsg_chip_noc_mc_credit_gate (max credits = 4).
module tb_bsg_chip_noc_mc_credit_gate;

  localparam int unsigned FW = 100;
  localparam int unsigned RW = 40;
  localparam int unsigned MC = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          fwd_v, fwd_ready, fwd_v_out, fwd_ready_link;
  logic [FW-1:0] fwd_data, fwd_data_out;
  logic          rev_v, rev_ready, rev_v_out, rev_ready_core;
  logic [RW-1:0] rev_data, rev_data_out;
  logic          drain, drained, error;
  logic [CW-1:0] credits;
`ifdef BSG_MC_CREDIT_GATE_STATS_EN
  logic [31:0]   stall_cycles;
  logic [CW-1:0] max_used;
`endif

  int checks   = 0;
  int failures = 0;
  int accepted;

  always #5 clk = ~clk;

  bsg_chip_noc_mc_credit_gate #(
    .fwd_width_p(FW), .rev_width_p(RW), .max_out_credits_p(MC)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .fwd_v_i(fwd_v), .fwd_data_i(fwd_data), .fwd_ready_and_o(fwd_ready),
    .fwd_v_o(fwd_v_out), .fwd_data_o(fwd_data_out), .fwd_ready_and_i(fwd_ready_link),
    .rev_v_i(rev_v), .rev_data_i(rev_data), .rev_ready_and_o(rev_ready),
    .rev_v_o(rev_v_out), .rev_data_o(rev_data_out), .rev_ready_and_i(rev_ready_core),
    .drain_i(drain), .drained_o(drained), .credits_used_o(credits), .error_o(error)
`ifdef BSG_MC_CREDIT_GATE_STATS_EN
    , .stall_cycles_o(stall_cycles), .max_used_o(max_used)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    fwd_v = 0; fwd_data = '0; fwd_ready_link = 0;
    rev_v = 0; rev_data = '0; rev_ready_core = 0;
    drain = 0;
    do_reset();

    // Reset state
    check("rst_fwd_v",   128'(fwd_v_out), 128'(0));
    check("rst_credits", 128'(credits),   128'(0));
    check("rst_error",   128'(error),     128'(0));
    check("rst_drained", 128'(drained),   128'(0));
    check("rst_ready",   128'(fwd_ready), 128'(1));

    // Basic flow: 4 back-to-back packets, each visible one cycle after acceptance
    fwd_ready_link = 1;
    for (int i = 0; i < 4; i++) begin
      fwd_v = 1; fwd_data = FW'(32'hA0 + i);
      check("basic_ready", 128'(fwd_ready), 128'(1));
      step();
      check("basic_v",    128'(fwd_v_out),    128'(1));
      check("basic_data", 128'(fwd_data_out), 128'(32'hA0 + i));
    end
    fwd_v = 0;
    step();
    check("basic_empty",   128'(fwd_v_out), 128'(0));
    check("basic_credits", 128'(credits),   128'(4));
    check("basic_sat",     128'(fwd_ready), 128'(0));

    // Returns pass through combinationally and release credits
    rev_ready_core = 1; rev_v = 1; rev_data = RW'(8'h5A);
    #1;
    check("rev_v_pass",     128'(rev_v_out),    128'(1));
    check("rev_data_pass",  128'(rev_data_out), 128'(8'h5A));
    check("rev_ready_pass", 128'(rev_ready),    128'(1));
    repeat (4) step();
    rev_v = 0;
    #1;
    check("basic_ret_credits", 128'(credits), 128'(0));
    check("basic_ret_error",   128'(error),   128'(0));
    check("rev_v_drop",        128'(rev_v_out), 128'(0));

    // Saturation: offer 6, exactly 4 accepted
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      fwd_v = 1; fwd_data = FW'(32'hB0 + i);
      #0;
      if (fwd_ready) accepted++;
      step();
    end
    check("sat_accepted", 128'(accepted),  128'(4));
    check("sat_ready",    128'(fwd_ready), 128'(0));
    check("sat_credits",  128'(credits),   128'(4));
    fwd_data = FW'(32'hB6);
    rev_v = 1;
    step();
    rev_v = 0;
    check("sat_ret_ready",   128'(fwd_ready), 128'(1));
    check("sat_ret_credits", 128'(credits),   128'(3));
    step();
    fwd_v = 0;
    check("sat_5th_credits", 128'(credits),      128'(4));
    check("sat_5th_ready",   128'(fwd_ready),    128'(0));
    check("sat_5th_data",    128'(fwd_data_out), 128'(32'hB6));
    step();
    rev_v = 1;
    repeat (4) step();
    rev_v = 0;
    check("sat_clear", 128'(credits), 128'(0));

    // Backpressure: link stalled, only two fit in the FIFO
    fwd_ready_link = 0;
    fwd_v = 1; fwd_data = FW'(32'hC0);
    step();
    fwd_data = FW'(32'hC1);
    step();
    fwd_data = FW'(32'hC2);
    check("bp_full_ready", 128'(fwd_ready), 128'(0));
    step();
    check("bp_credits",   128'(credits),      128'(2));
    check("bp_head",      128'(fwd_data_out), 128'(32'hC0));
    check("bp_still_blk", 128'(fwd_ready),    128'(0));
    fwd_ready_link = 1;
    step();
    check("bp_rel_1", 128'(fwd_data_out), 128'(32'hC1));
    check("bp_rel_rdy", 128'(fwd_ready),  128'(1));
    step();
    fwd_v = 0;
    check("bp_rel_2", 128'(fwd_data_out), 128'(32'hC2));
    step();
    check("bp_done_v",     128'(fwd_v_out), 128'(0));
    check("bp_done_creds", 128'(credits),   128'(3));

    // Simultaneous accept and return leaves the count unchanged
    fwd_v = 1; fwd_data = FW'(32'hD0); rev_v = 1;
    step();
    fwd_v = 0;
    check("simul_credits", 128'(credits), 128'(3));
    repeat (3) step();
    check("simul_zero", 128'(credits), 128'(0));
    check("pre_uf_err", 128'(error),   128'(0));
    step();
    rev_v = 0;
    check("uf_error",   128'(error),   128'(1));
    check("uf_credits", 128'(credits), 128'(0));
    repeat (3) step();
    check("uf_sticky", 128'(error), 128'(1));

    // Reset mid-operation clears the sticky error
    do_reset();
    check("rst2_error",   128'(error),   128'(0));
    check("rst2_credits", 128'(credits), 128'(0));

    // Drain: two already sent, one buffered
    fwd_ready_link = 1;
    fwd_v = 1; fwd_data = FW'(32'hE0);
    step();
    fwd_data = FW'(32'hE1);
    step();
    fwd_v = 0;
    step();
    fwd_ready_link = 0;
    fwd_v = 1; fwd_data = FW'(32'hE2);
    step();
    fwd_v = 0; drain = 1;
    step();
    check("drain_credits", 128'(credits), 128'(3));
    fwd_v = 1; fwd_data = FW'(32'hE3);
    #0;
    check("drain_blocked", 128'(fwd_ready), 128'(0));
    step();
    check("drain_no_acc", 128'(credits),      128'(3));
    check("drain_buf_v",  128'(fwd_v_out),    128'(1));
    check("drain_buf_d",  128'(fwd_data_out), 128'(32'hE2));
    fwd_ready_link = 1;
    step();
    fwd_v = 0;
    check("drain_emitted", 128'(fwd_v_out), 128'(0));
    rev_v = 1;
    repeat (3) step();
    rev_v = 0;
    check("drain_ret_credits", 128'(credits), 128'(0));
    check("drain_not_yet",     128'(drained), 128'(0));
    step();
    check("drained",       128'(drained),   128'(1));
    check("drained_ready", 128'(fwd_ready), 128'(0));
    drain = 0;
    step();
    check("undrain",       128'(drained),   128'(0));
    check("undrain_ready", 128'(fwd_ready), 128'(1));
    check("drain_error",   128'(error),     128'(0));
`ifdef BSG_MC_CREDIT_GATE_STATS_EN
    check("max_used_3", 128'(max_used), 128'(3));
`endif

    // Fill to saturation, then hold fwd_v for 10 stalled cycles
    fwd_v = 1; fwd_data = FW'(32'hF0);
    repeat (4) step();
    check("fill_credits", 128'(credits), 128'(4));
    repeat (10) step();
    fwd_v = 0;
    check("stall_ready", 128'(fwd_ready), 128'(0));
`ifdef BSG_MC_CREDIT_GATE_STATS_EN
    check("stall_cycles", 128'(stall_cycles), 128'(10));
    check("max_used_4",   128'(max_used),     128'(4));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
